cordic_comp: RTL and testbench

- Iterative rotation-mode CORDIC that computes cos or sin of an 8-bit signed angle.
- Performs one micro-rotation per clock.
- The angle is captured while reset is held; iteration starts when reset is released.
- Standalone arithmetic block; the output is a registered 8-bit Q1.6 value.
- Declared port order is fixed for positional instantiation: z_initial_in, rst, clk, cordic_out.

---
 rtl/cordic_comp.sv | 118 +++++++++++
 tb/tb_cordic_comp.sv | 130 +++++++++++++
 2 files changed

// File: rtl/cordic_comp.sv
// ----------------------------------------------------------------------------
// cordic_comp
//
// Iterative rotation-mode CORDIC producing cos or sin of an 8-bit signed
// angle in Q1.6 (value/64).  One micro-rotation is performed per clock.
// The angle is loaded while rst is held high and the rotations start
// automatically on the first edge with rst low.  After the last rotation
// the result is latched into cordic_out and everything freezes until the
// next reset.
//
// Parameters
//   ITERATIONS : number of micro-rotations, 1..7
//   OUT_SEL    : 0 = cosine (x path), 1 = sine (y path)
//
// Ports
//   z_initial_in : target angle, signed Q1.6, sampled only on reset edges
//   rst          : synchronous active-high reset
//   clk          : rising-edge clock
//   cordic_out   : registered signed Q1.6 result, 0 until completion
// ----------------------------------------------------------------------------
module cordic_comp #(
    parameter int ITERATIONS = 5,
    parameter bit OUT_SEL    = 1'b0
) (
    input  logic [7:0] z_initial_in,
    input  logic       rst,
    input  logic       clk,
    output logic [7:0] cordic_out
);

    // Starting x is pre-scaled by the inverse CORDIC gain so the final
    // vector has unit length; the gain converges after a few rotations.
    localparam logic signed [7:0] K = (ITERATIONS == 1) ? 8'sd45 :
                                      (ITERATIONS == 2) ? 8'sd40 : 8'sd39;

    localparam logic [2:0] LAST_ITER = 3'(ITERATIONS - 1);

    logic signed [7:0] x_q, x_d;
    logic signed [7:0] y_q, y_d;
    logic signed [7:0] z_q, z_d;
    logic [2:0]        i_q, i_d;
    logic              done_q, done_d;
    logic [7:0]        out_q, out_d;

    logic signed [7:0] xShift;
    logic signed [7:0] yShift;
    logic signed [7:0] atanVal;

    // Arctangent lookup of 2^-i in Q1.6.
    always_comb begin
        atanVal = 8'sd0;
        case (i_q)
            3'd0:    atanVal = 8'sd50;
            3'd1:    atanVal = 8'sd30;
            3'd2:    atanVal = 8'sd16;
            3'd3:    atanVal = 8'sd8;
            3'd4:    atanVal = 8'sd4;
            3'd5:    atanVal = 8'sd2;
            3'd6:    atanVal = 8'sd1;
            default: atanVal = 8'sd0;
        endcase
    end

    // One micro-rotation: the sign of the residual angle picks the rotation
    // direction, and x, y, z are all updated from their old values.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        z_d    = z_q;
        i_d    = i_q;
        done_d = done_q;
        out_d  = out_q;
        xShift = x_q >>> i_q;
        yShift = y_q >>> i_q;

        if (!done_q) begin
            if (!z_q[7]) begin
                x_d = x_q - yShift;
                y_d = y_q + xShift;
                z_d = z_q - atanVal;
            end else begin
                x_d = x_q + yShift;
                y_d = y_q - xShift;
                z_d = z_q + atanVal;
            end
            i_d = i_q + 3'd1;

            // The final rotation's result goes straight to the output
            // register so no intermediate value is ever visible.
            if (i_q == LAST_ITER) begin
                done_d = 1'b1;
                out_d  = OUT_SEL ? y_d : x_d;
            end
        end
    end

    // State registers; reset also captures the angle.
    always_ff @(posedge clk) begin
        if (rst) begin
            x_q    <= K;
            y_q    <= 8'sd0;
            z_q    <= z_initial_in;
            i_q    <= 3'd0;
            done_q <= 1'b0;
            out_q  <= 8'd0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            z_q    <= z_d;
            i_q    <= i_d;
            done_q <= done_d;
            out_q  <= out_d;
        end
    end

    assign cordic_out = out_q;

endmodule

// File: tb/tb_cordic_comp.sv
// ----------------------------------------------------------------------------
// tb_cordic_comp
//
// Drives four cordic_comp instances with different ITERATIONS/OUT_SEL
// settings from a shared angle/reset and compares every output after every
// clock edge against a plain-arithmetic CORDIC model.
// ----------------------------------------------------------------------------
module tb_cordic_comp;

    logic       clk;
    logic       rst;
    logic [7:0] zIn;
    logic [7:0] couts [4];

    int assertions = 0;
    int failures   = 0;

    int iterCfg [4] = '{5, 5, 2, 7};
    bit selCfg  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};

    cordic_comp #(.ITERATIONS(5), .OUT_SEL(1'b0)) dut0 (
        .z_initial_in(zIn), .rst(rst), .clk(clk), .cordic_out(couts[0]));
    cordic_comp #(.ITERATIONS(5), .OUT_SEL(1'b1)) dut1 (
        .z_initial_in(zIn), .rst(rst), .clk(clk), .cordic_out(couts[1]));
    cordic_comp #(.ITERATIONS(2), .OUT_SEL(1'b0)) dut2 (
        .z_initial_in(zIn), .rst(rst), .clk(clk), .cordic_out(couts[2]));
    cordic_comp #(.ITERATIONS(7), .OUT_SEL(1'b1)) dut3 (
        .z_initial_in(zIn), .rst(rst), .clk(clk), .cordic_out(couts[3]));

    // Free-running clock, period 10, first rising edge at t=5.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference CORDIC: start from (K, 0, angle) and rotate toward zero
    // residual angle, every quantity kept as an 8-bit wrapping integer.
    function automatic logic [7:0] model(input logic [7:0] angle, input int iters, input bit sel);
        int  atanTab [7] = '{50, 30, 16, 8, 4, 2, 1};
        byte x, y, z, xNew, yNew;
        x = (iters == 1) ? 8'sd45 : (iters == 2) ? 8'sd40 : 8'sd39;
        y = 0;
        z = byte'(angle);
        for (int i = 0; i < iters; i++) begin
            if (z >= 0) begin
                xNew = x - (y >>> i);
                yNew = y + (x >>> i);
                z    = z - byte'(atanTab[i]);
            end else begin
                xNew = x + (y >>> i);
                yNew = y - (x >>> i);
                z    = z + byte'(atanTab[i]);
            end
            x = xNew;
            y = yNew;
        end
        return sel ? y : x;
    endfunction

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        assertions++;
        assert (obs === exp)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    // Hold reset across one rising edge with the given angle, release it,
    // then check every instance after each of the following edges.  With
    // glitch set the angle input is scrambled mid-run; the model keeps the
    // captured angle.
    task automatic applyStimulus(input logic [7:0] angle, input int cycles, input bit glitch);
        logic [7:0] expected;
        rst = 1'b1;
        zIn = angle;
        @(negedge clk);
        for (int j = 0; j < 4; j++)
            checkOutput($sformatf("reset dut%0d angle=%0d", j, $signed(angle)), couts[j], 8'd0);
        rst = 1'b0;
        for (int k = 1; k <= cycles; k++) begin
            @(negedge clk);
            for (int j = 0; j < 4; j++) begin
                expected = (k >= iterCfg[j]) ? model(angle, iterCfg[j], selCfg[j]) : 8'd0;
                checkOutput($sformatf("dut%0d angle=%0d edge=%0d", j, $signed(angle), k),
                            couts[j], expected);
            end
            if (glitch && k == 2)
                zIn = ~angle;
        end
    endtask

    initial begin
        logic [7:0] angle;
        rst = 1'b1;
        zIn = 8'd67;

        // Nominal 60 degree case, also held for 10 cycles past completion.
        applyStimulus(8'd67, 15, 1'b0);
        checkOutput("cos60 literal", couts[0], 8'd31);
        checkOutput("sin60 literal", couts[1], 8'd56);

        // Zero angle and the negative mirror.
        applyStimulus(8'd0, 6, 1'b0);
        checkOutput("cos0 literal", couts[0], 8'd64);
        applyStimulus(8'hBD, 6, 1'b0);
        checkOutput("cos-60 literal", couts[0], 8'd31);

        // Extremes of the legal range.
        applyStimulus(8'sd111, 8, 1'b0);
        applyStimulus(-8'sd111, 8, 1'b0);

        // Abort after two rotations and restart with a new angle.
        applyStimulus(8'd67, 2, 1'b0);
        applyStimulus(8'd0, 8, 1'b0);
        checkOutput("restart cos0 literal", couts[0], 8'd64);

        // Angle input changes while running must have no effect.
        applyStimulus(8'd67, 15, 1'b1);
        checkOutput("glitch cos60 literal", couts[0], 8'd31);

        // Random legal angles.
        for (int n = 0; n < 12; n++) begin
            angle = 8'($urandom_range(0, 222) - 111);
            applyStimulus(angle, 8, n[0]);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
        $finish;
    end

endmodule
